// File: rtl/inst_rom_loader_if.sv
// Bus bundle between the core-side fetch port / image load stream and
// inst_rom_loader. The master drives fetch requests and load bytes; the
// slave (the loader) returns instructions and load-ready.
interface inst_rom_loader_if;
  logic        ce_i;
  logic [31:0] addr_i;
  logic [31:0] inst_o;
  logic        ld_valid_i;
  logic        ld_ready_o;
  logic [7:0]  ld_data_i;
  logic        ld_last_i;

  modport master (
    output ce_i, addr_i, ld_valid_i, ld_data_i, ld_last_i,
    input  inst_o, ld_ready_o
  );

  modport slave (
    input  ce_i, addr_i, ld_valid_i, ld_data_i, ld_last_i,
    output inst_o, ld_ready_o
  );
endinterface

// File: rtl/inst_rom_loader.sv
// Instruction ROM responder with a byte-stream image loader.
// Holds the core in reset while a big-endian byte image is assembled into
// 32-bit words, then releases the core and serves fetches combinationally.
module inst_rom_loader #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,          // async, active-low
  inst_rom_loader_if.slave      bus,
  output logic                  cpu_rst_o,
  output logic                  load_done_o,
  output logic [DEPTH_LOG2:0]   load_cnt_o,
  output logic                  err_o,
  output logic [1:0]            state_o       // debug view of the FSM state
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t      state;
  logic [1:0]  byte_idx;
  logic [31:0] word_buf;
  logic [31:0] mem [DEPTH];

  // Load handshake: a byte moves on a rising edge where ld_valid_i and
  // ld_ready_o are both high. The source must hold ld_data_i/ld_last_i
  // stable while ld_valid_i is high and not yet accepted; ld_ready_o is a
  // pure decode of the registered state (high until the image is complete).
  logic accept;
  logic write_word;
  logic full;
  logic [31:0] merged;

  assign bus.ld_ready_o = (state != RUN);
  assign accept         = bus.ld_valid_i && bus.ld_ready_o;
  assign write_word     = accept && ((byte_idx == 2'd3) || bus.ld_last_i);
  assign full           = (load_cnt_o == FULL_CNT);
  assign state_o        = state;

  // Merge the incoming byte into the word buffer, big-endian.
  always_comb begin
    merged = word_buf;
    case (byte_idx)
      2'd0:    merged[31:24] = bus.ld_data_i;
      2'd1:    merged[23:16] = bus.ld_data_i;
      2'd2:    merged[15:8]  = bus.ld_data_i;
      default: merged[7:0]   = bus.ld_data_i;
    endcase
  end

  // Loader FSM: assembles bytes, counts words, flags overflow, releases the core.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      byte_idx    <= 2'd0;
      word_buf    <= 32'h0;
      load_cnt_o  <= '0;
      cpu_rst_o   <= 1'b1;
      load_done_o <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      case (state)
        IDLE, LOAD: begin
          if (accept) begin
            if (write_word) begin
              // A word past the end of the array is dropped, but the
              // stream keeps flowing so the source can finish cleanly.
              if (full) err_o      <= 1'b1;
              else      load_cnt_o <= load_cnt_o + 1'b1;
              byte_idx <= 2'd0;
              word_buf <= 32'h0;
            end else begin
              byte_idx <= byte_idx + 2'd1;
              word_buf <= merged;
            end
            if (bus.ld_last_i) begin
              state       <= RUN;
              cpu_rst_o   <= 1'b0;
              load_done_o <= 1'b1;
            end else begin
              state <= LOAD;
            end
          end
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  // Word array write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (write_word && !full) begin
      mem[load_cnt_o[DEPTH_LOG2-1:0]] <= merged;
    end
  end

  // Zero-latency fetch: only loaded, in-range words are visible, and only
  // once the core is running; everything else reads as NOP (0).
  logic [DEPTH_LOG2-1:0] idx;
  logic                  hit;

  assign idx = bus.addr_i[DEPTH_LOG2+1:2];
  assign hit = bus.ce_i && (state == RUN) &&
               (bus.addr_i[31:DEPTH_LOG2+2] == '0) &&
               ({1'b0, idx} < load_cnt_o);

  // Fetch read mux.
  always_comb begin
    bus.inst_o = 32'h0;
    if (hit) bus.inst_o = mem[idx];
  end

endmodule

// File: tb/tb_inst_rom_loader.sv
// Scoreboard bench for inst_rom_loader: a default-depth instance for the
// main image tests and a DEPTH_LOG2=2 instance for overflow.
module tb_inst_rom_loader;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  inst_rom_loader_if bus_b ();
  inst_rom_loader_if bus_s ();

  logic        cpu_rst_b, done_b, err_b;
  logic [10:0] cnt_b;
  logic [1:0]  state_b;
  logic        cpu_rst_s, done_s, err_s;
  logic [2:0]  cnt_s;
  logic [1:0]  state_s;

  inst_rom_loader #(.DEPTH_LOG2(10)) u_dut (
    .clk(clk), .rst(rst), .bus(bus_b),
    .cpu_rst_o(cpu_rst_b), .load_done_o(done_b), .load_cnt_o(cnt_b),
    .err_o(err_b), .state_o(state_b)
  );

  inst_rom_loader #(.DEPTH_LOG2(2)) u_small (
    .clk(clk), .rst(rst), .bus(bus_s),
    .cpu_rst_o(cpu_rst_s), .load_done_o(done_s), .load_cnt_o(cnt_s),
    .err_o(err_s), .state_o(state_s)
  );

  // ---------------- scoreboard ----------------
  localparam int S_INST   = 0;
  localparam int S_CNT    = 1;
  localparam int S_DONE   = 2;
  localparam int S_CPURST = 3;
  localparam int S_ERR    = 4;
  localparam int S_READY  = 5;
  localparam int S_STATE  = 6;
  localparam int T_INST   = 7;
  localparam int T_CNT    = 8;
  localparam int T_ERR    = 9;
  localparam int T_DONE   = 10;

  logic [31:0] exp_q[$];
  int          sel_q[$];
  string       name_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      S_INST:   return bus_b.inst_o;
      S_CNT:    return {21'h0, cnt_b};
      S_DONE:   return {31'h0, done_b};
      S_CPURST: return {31'h0, cpu_rst_b};
      S_ERR:    return {31'h0, err_b};
      S_READY:  return {31'h0, bus_b.ld_ready_o};
      S_STATE:  return {30'h0, state_b};
      T_INST:   return bus_s.inst_o;
      T_CNT:    return {29'h0, cnt_s};
      T_ERR:    return {31'h0, err_s};
      T_DONE:   return {31'h0, done_s};
      default:  return 32'hDEAD_DEAD;
    endcase
  endfunction

  // Monitor: pops queued expectations and compares on the falling edge.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [31:0] e;
      logic [31:0] a;
      int          s;
      string       n;
      e = exp_q.pop_front();
      s = sel_q.pop_front();
      n = name_q.pop_front();
      a = obs(s);
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got %h, expected %h", n, a, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input int sel, input logic [31:0] exp, input string name);
    exp_q.push_back(exp);
    sel_q.push_back(sel);
    name_q.push_back(name);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Offer one byte to instance `which` (0 = default depth, 1 = small)
  // after 0-2 idle cycles; returns #1 after the accepting edge.
  task automatic send_byte(input int which, input logic [7:0] d, input logic last);
    int n;
    int stall;
    logic rdy;
    @(posedge clk); #1;
    stall = $urandom_range(0, 2);
    repeat (stall) begin
      @(posedge clk); #1;
    end
    if (which == 0) begin
      bus_b.ld_valid_i = 1'b1; bus_b.ld_data_i = d; bus_b.ld_last_i = last;
    end else begin
      bus_s.ld_valid_i = 1'b1; bus_s.ld_data_i = d; bus_s.ld_last_i = last;
    end
    n = 0;
    forever begin
      @(negedge clk);
      rdy = (which == 0) ? bus_b.ld_ready_o : bus_s.ld_ready_o;
      if (rdy) break;
      n++;
      if (n > 50) begin
        n_checks++;
        n_fail++;
        $display("FAIL ready_timeout: got ld_ready_o=0 for 50 cycles, expected 1");
        break;
      end
    end
    @(posedge clk); #1;
    if (which == 0) begin
      bus_b.ld_valid_i = 1'b0; bus_b.ld_last_i = 1'b0;
    end else begin
      bus_s.ld_valid_i = 1'b0; bus_s.ld_last_i = 1'b0;
    end
  endtask

  task automatic fetch(input logic ce, input logic [31:0] a);
    bus_b.ce_i   = ce;
    bus_b.addr_i = a;
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] img1 [8] = '{8'h34, 8'h01, 8'h00, 8'h05, 8'h34, 8'h02, 8'h00, 8'h0A};
  logic [7:0] img2 [6] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
  logic [7:0] img3 [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};

  initial begin
    bus_b.ce_i = 1'b0; bus_b.addr_i = 32'h0;
    bus_b.ld_valid_i = 1'b0; bus_b.ld_data_i = 8'h0; bus_b.ld_last_i = 1'b0;
    bus_s.ce_i = 1'b0; bus_s.addr_i = 32'h0;
    bus_s.ld_valid_i = 1'b0; bus_s.ld_data_i = 8'h0; bus_s.ld_last_i = 1'b0;

    // Reset state while rst is held low.
    fetch(1'b1, 32'h0);
    check(S_CNT,    32'd0, "rst_cnt");
    check(S_CPURST, 32'd1, "rst_cpu_rst");
    check(S_DONE,   32'd0, "rst_done");
    check(S_ERR,    32'd0, "rst_err");
    check(S_READY,  32'd1, "rst_ready");
    check(S_STATE,  32'd0, "rst_state");
    check(S_INST,   32'h0, "rst_inst");
    @(posedge clk); #1 rst = 1'b1;

    // Image 1: two full words, with random stalls between bytes.
    for (int i = 0; i < 7; i++) send_byte(0, img1[i], 1'b0);
    check(S_STATE,  32'd1, "load_state");
    check(S_CPURST, 32'd1, "load_cpu_rst");
    check(S_READY,  32'd1, "load_ready");
    check(S_INST,   32'h0, "load_fetch_gated");
    send_byte(0, img1[7], 1'b1);
    check(S_CPURST, 32'd0, "img1_cpu_rst_release");
    check(S_DONE,   32'd1, "img1_done");
    check(S_CNT,    32'd2, "img1_cnt");
    check(S_INST,   32'h3401_0005, "img1_word0");
    fetch(1'b1, 32'h4);
    check(S_INST,   32'h3402_000A, "img1_word1");
    fetch(1'b1, 32'h5);
    check(S_INST,   32'h3402_000A, "img1_word1_lowbits");
    fetch(1'b1, 32'h8);
    check(S_INST,   32'h0, "img1_unloaded");
    fetch(1'b0, 32'h0);
    check(S_INST,   32'h0, "run_ce_low");
    fetch(1'b1, 32'h8000_0000);
    check(S_INST,   32'h0, "run_addr_high");
    check(S_READY,  32'd0, "run_ready");

    // Bytes offered in RUN must be ignored.
    @(posedge clk); #1;
    bus_b.ld_valid_i = 1'b1; bus_b.ld_data_i = 8'hFF; bus_b.ld_last_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus_b.ld_valid_i = 1'b0; bus_b.ld_last_i = 1'b0;
    fetch(1'b1, 32'h0);
    check(S_CNT,    32'd2, "run_ignore_cnt");
    check(S_INST,   32'h3401_0005, "run_ignore_word0");
    check(S_ERR,    32'd0, "run_ignore_err");

    // Image 2: last byte mid-word -> zero padded partial word.
    do_reset();
    for (int i = 0; i < 6; i++) send_byte(0, img2[i], i == 5);
    fetch(1'b1, 32'h0);
    check(S_INST,   32'hAABB_CCDD, "img2_word0");
    fetch(1'b1, 32'h4);
    check(S_INST,   32'h1122_0000, "img2_word1_padded");
    check(S_CNT,    32'd2, "img2_cnt");

    // Overflow on the 4-word instance: 20 bytes, only 16 stored.
    for (int i = 0; i < 19; i++) begin
      send_byte(1, 8'(i + 1), 1'b0);
      if (i == 15) check(T_CNT, 32'd4, "ovf_cnt_full");
    end
    check(T_ERR,  32'd0, "ovf_err_before");
    send_byte(1, 8'h14, 1'b1);
    check(T_ERR,  32'd1, "ovf_err_set");
    check(T_CNT,  32'd4, "ovf_cnt_final");
    check(T_DONE, 32'd1, "ovf_done");
    bus_s.ce_i = 1'b1;
    for (int w = 0; w < 4; w++) begin
      logic [7:0] b0;
      b0 = 8'(4 * w + 1);
      bus_s.addr_i = 32'(4 * w);
      check(T_INST, {b0, b0 + 8'd1, b0 + 8'd2, b0 + 8'd3}, "ovf_word");
    end
    bus_s.addr_i = 32'h10;
    check(T_INST, 32'h0, "ovf_addr_out_of_range");

    // Reset mid-word: registers return at once, without a clock edge.
    do_reset();
    send_byte(0, 8'h11, 1'b0);
    send_byte(0, 8'h22, 1'b0);
    #1 rst = 1'b0;
    check(S_CPURST, 32'd1, "async_cpu_rst");
    check(S_CNT,    32'd0, "async_cnt");
    check(S_READY,  32'd1, "async_ready");
    check(S_STATE,  32'd0, "async_state");
    @(posedge clk); #1 rst = 1'b1;
    for (int i = 0; i < 4; i++) send_byte(0, img3[i], i == 3);
    fetch(1'b1, 32'h0);
    check(S_INST,   32'hDEAD_BEEF, "reload_word0");
    check(S_CNT,    32'd1, "reload_cnt");

    // Single-byte image straight from IDLE, after a mid-word reset.
    do_reset();
    send_byte(0, 8'h33, 1'b0);
    send_byte(0, 8'h44, 1'b0);
    do_reset();
    send_byte(0, 8'h77, 1'b1);
    check(S_INST,   32'h7700_0000, "single_byte_word");
    check(S_CNT,    32'd1, "single_byte_cnt");
    check(S_DONE,   32'd1, "single_byte_done");

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL queue_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
